button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions a raw mechanical push-button into a clean, clock-synchronous level plus single-cycle press, release and long-press event pulses. It sits directly upstream of the LED blink logic on the 50 MHz board clock. Its pulses drive that logic's enable, mode and clear inputs, so they never carry bounce or metastability.

## Interface
Parameters:
- STABLE_CYCLES, default 1_000_000 (20 ms @ 50 MHz): consecutive cycles a new input level must persist before it is accepted; legal range ≥ 2.
- LONG_CYCLES, default 50_000_000 (1 s): cycles from press acceptance to the long-press event; must be greater than STABLE_CYCLES.
- ACTIVE_LOW, default 1: 1 means the button reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_async  in  1  reset, asynchronous, active-high.
  - Assertion may occur at any time.
  - Deassertion is synchronous to clk; the top level provides this with the existing double-FF reset synchronizer.
- btn_raw  in  1  raw button pin, asynchronous to clk.
- btn_level  out  1  debounced state; 1 means pressed, independent of ACTIVE_LOW.
- press_pulse  out  1  one-cycle pulse on accepted press.
- release_pulse  out  1  one-cycle pulse on accepted release.
- long_press_pulse  out  1  one-cycle pulse once per press held for LONG_CYCLES.

## Operation
- **Synchronizer:** two flip-flops on btn_raw. Both reset to the inactive raw value: 1 if ACTIVE_LOW, else 0.
- **Normalization:** btn_n = sync output XOR ACTIVE_LOW, so btn_n = 1 means pressed.
- **Stability counter:** stab_cnt, width $clog2(STABLE_CYCLES). On every clk edge:
  - If btn_n == btn_level: stab_cnt <= 0.
  - Else, if stab_cnt == STABLE_CYCLES-1: btn_level <= btn_n, stab_cnt <= 0, and assert press_pulse (if btn_n = 1) or release_pulse (if btn_n = 0).
  - Else: stab_cnt <= stab_cnt + 1.
- **State machine:** IDLE, PRESS_PEND, PRESSED, RELEASE_PEND.
  - IDLE → PRESS_PEND when btn_n = 1.
  - PRESS_PEND → IDLE if btn_n returns to 0; → PRESSED on commit.
  - PRESSED → RELEASE_PEND when btn_n = 0.
  - RELEASE_PEND → PRESSED if btn_n returns to 1; → IDLE on commit.
- **Hold counter:** hold_cnt, width $clog2(LONG_CYCLES), plus a long_done flag.
  - Both cleared on press commit.
  - While btn_level = 1 and long_done = 0: if hold_cnt == LONG_CYCLES-1, assert long_press_pulse and set long_done; otherwise increment.
  - Bounce inside PRESSED or RELEASE_PEND does not reset hold_cnt.
- **Simultaneous events:** if the release commits on the same edge the long press would fire, release wins. long_press_pulse stays 0 and release_pulse asserts.
- **No-overlap guarantee:** press_pulse and release_pulse are never high together. long_press_pulse is never high in the same cycle as either.
- **Reset values:** all outputs 0; both counters 0; long_done 0; state IDLE.
- **Reset mid-press:** outputs drop to 0 immediately. No release_pulse is emitted. If the button is still held after deassertion, a fresh press is detected with full latency.

## Timing
- All outputs are registered; there is no combinational path from btn_raw.
- Take edge 1 as the first clk edge that samples a new btn_raw value.
  - btn_n changes after edge 2.
  - The commit, and the associated pulse, appears after edge STABLE_CYCLES+2.
  - btn_level changes in that same cycle, coincident with the pulse.
- **Long-press timing:** long_press_pulse rises exactly LONG_CYCLES cycles after the press_pulse cycle, provided no release has committed by then.
- **Pulse width:** each pulse is exactly one clk cycle.
- **Glitch rejection:**
  - Any excursion of btn_n lasting ≤ STABLE_CYCLES-1 cycles produces no output change.
  - An excursion lasting exactly STABLE_CYCLES cycles is accepted.

## Test plan
All scenarios use STABLE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1.
- **Reset, then held button:** hold rst_async with btn_raw=0 → all outputs 0. Deassert rst_async with btn_raw held at 0 → press_pulse and btn_level rise after the 6th post-reset edge; press_pulse is high for 1 cycle.
- **Bounce rejection:** btn_raw alternates 0 for 3 cycles / 1 for 2 cycles, repeated 10 times → btn_level stays 0 with no pulses. A 3-cycle low excursion while pressed → no release_pulse.
- **Clean press and release:** btn_raw=0 for 8 cycles, then 1 → press_pulse 6 cycles after the first low sample; release_pulse 6 cycles after the first high sample. btn_level is high for exactly 8 cycles; no long_press_pulse.
- **Long press:** btn_raw=0 held for 30 cycles → long_press_pulse exactly once, 10 cycles after press_pulse. A later release gives one release_pulse and no second long pulse.
- **Simultaneous events:** time the release so its commit lands on the same edge as the long-press threshold → release_pulse=1 and long_press_pulse=0 in that cycle and afterwards.
- **Reset mid-press:** assert rst_async 3 cycles after press_pulse, asynchronously to clk → btn_level drops immediately with no release_pulse. Deassert with btn_raw still 0 → a new press_pulse after the 6th edge.

Source files
------------

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw mechanical push-button into a clean, clk-synchronous pressed
// level. It also produces single-cycle press, release and long-press event
// pulses. The raw pin passes through a two-flop synchronizer and is normalised
// so that 1 means pressed. A new level is accepted only after it has been seen
// on STABLE_CYCLES consecutive edges. The long-press event fires LONG_CYCLES
// cycles after the press is accepted, at most once per press.
//
// Ports:
//   clk              in   system clock
//   rst_async        in   asynchronous active-high reset (sync deassertion)
//   btn_raw          in   raw button pin, asynchronous to clk
//   btn_level        out  debounced state, 1 = pressed (any polarity)
//   press_pulse      out  one-cycle pulse on accepted press
//   release_pulse    out  one-cycle pulse on accepted release
//   long_press_pulse out  one-cycle pulse once per press held LONG_CYCLES
//
// States:
//   state          | meaning
//   S_IDLE         | released and stable
//   S_PRESS_PEND   | released, pressed level seen, waiting for stability
//   S_PRESSED      | pressed and stable
//   S_RELEASE_PEND | pressed, released level seen, waiting for stability
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst_async,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int SW = $clog2(STABLE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          w_btn_n;
    logic [SW-1:0] r_stab_cnt;
    logic          w_commit;
    state_t        r_state;
    state_t        w_state_next;
    logic          w_press_commit;
    logic          w_release_commit;
    logic [LW-1:0] r_hold_cnt;
    logic          r_long_done;
    logic          w_long_fire;

    // Synchronizer flops idle at the released raw level so that reset does not
    // look like a press.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_n  = r_sync2 ^ ACTIVE_LOW;
    assign w_commit = (w_btn_n != btn_level) && (r_stab_cnt == STAB_LAST);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_stab_cnt <= '0;
            btn_level  <= 1'b0;
        end else if (w_btn_n == btn_level) begin
            r_stab_cnt <= '0;
        end else if (w_commit) begin
            r_stab_cnt <= '0;
            btn_level  <= w_btn_n;
        end else begin
            r_stab_cnt <= r_stab_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_press_commit   = 1'b0;
        w_release_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_btn_n) w_state_next = S_PRESS_PEND;
            end
            S_PRESS_PEND: begin
                if (w_commit) begin
                    w_state_next   = S_PRESSED;
                    w_press_commit = 1'b1;
                end else if (!w_btn_n) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PRESSED: begin
                if (!w_btn_n) w_state_next = S_RELEASE_PEND;
            end
            S_RELEASE_PEND: begin
                if (w_commit) begin
                    w_state_next     = S_IDLE;
                    w_release_commit = 1'b1;
                end else if (w_btn_n) begin
                    w_state_next = S_PRESSED;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // A release committing on the threshold edge suppresses the long event.
    assign w_long_fire = btn_level && !r_long_done && (r_hold_cnt == HOLD_LAST)
                         && !w_release_commit;

    // The hold counter ignores bounce: it runs on the accepted level only.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
        end else if (w_press_commit) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
        end else if (btn_level && !r_long_done) begin
            if (r_hold_cnt == HOLD_LAST) begin
                r_long_done <= 1'b1;
            end else begin
                r_hold_cnt <= r_hold_cnt + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            press_pulse      <= w_press_commit;
            release_pulse    <= w_release_commit;
            long_press_pulse <= w_long_fire;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

    localparam int K_PRESS = 1;
    localparam int K_REL   = 2;
    localparam int K_LONG  = 3;

    logic clk       = 1'b0;
    logic rst_async = 1'b1;
    logic btn_raw   = 1'b0;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    button_debouncer #(
        .STABLE_CYCLES(4),
        .LONG_CYCLES  (10),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk             (clk),
        .rst_async       (rst_async),
        .btn_raw         (btn_raw),
        .btn_level       (btn_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int at;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   int'(btn_level),        0);
        chk({tag, "_press"},   int'(press_pulse),      0);
        chk({tag, "_release"}, int'(release_pulse),    0);
        chk({tag, "_long"},    int'(long_press_pulse), 0);
    endtask

    // Monitor: every pulse the DUT presents is matched against the queue.
    always @(negedge clk) begin : monitor
        int   n;
        int   k;
        ev_t  e;
        if (!rst_async) begin
            n = int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse);
            if (n > 0) begin
                chk("pulse_overlap", n, 1);
                k = press_pulse ? K_PRESS : (release_pulse ? K_REL : K_LONG);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse_kind", k, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", k, e.kind);
                    chk("event_cycle", cyc, e.at);
                    if (k == K_PRESS) chk("level_at_press", int'(btn_level), 1);
                    if (k == K_REL)   chk("level_at_release", int'(btn_level), 0);
                end
            end
        end
    end

    initial begin : stim
        int t;
        int c1;

        // Reset with the button held pressed (raw low).
        rst_async = 1'b1;
        btn_raw   = 1'b0;
        step(3);
        chk_all_zero("reset");

        // Release reset while held: press after the 6th post-reset edge.
        rst_async = 1'b0;
        t = cyc;
        expect_ev(K_PRESS, t + 6);
        expect_ev(K_REL,   t + 14);
        step(8);
        chk("held_level", int'(btn_level), 1);
        btn_raw = 1'b1;
        step(12);

        // Bounce while released: 3 low / 2 high, never stable long enough.
        for (int r = 0; r < 10; r++) begin
            btn_raw = 1'b0;
            step(3);
            btn_raw = 1'b1;
            step(2);
        end
        step(8);
        chk("bounce_level", int'(btn_level), 0);

        // Press, 3-cycle high excursion (rejected, hold keeps running), release.
        t = cyc;
        btn_raw = 1'b0;
        expect_ev(K_PRESS, t + 6);
        expect_ev(K_LONG,  t + 16);
        expect_ev(K_REL,   t + 26);
        step(8);
        chk("pre_glitch_level", int'(btn_level), 1);
        btn_raw = 1'b1;
        step(3);
        btn_raw = 1'b0;
        step(9);
        chk("post_glitch_level", int'(btn_level), 1);
        btn_raw = 1'b1;
        step(10);
        chk("glitch_release_level", int'(btn_level), 0);

        // Clean press for 8 cycles then release: level high exactly 8 cycles.
        t = cyc;
        btn_raw = 1'b0;
        expect_ev(K_PRESS, t + 6);
        expect_ev(K_REL,   t + 14);
        for (int i = 1; i <= 16; i++) begin
            step(1);
            chk("clean_level", int'(btn_level), (i >= 6 && i <= 13) ? 1 : 0);
            if (i == 8) btn_raw = 1'b1;
        end
        step(4);

        // Long press: held 30 cycles, one long event, then one release.
        t = cyc;
        btn_raw = 1'b0;
        expect_ev(K_PRESS, t + 6);
        expect_ev(K_LONG,  t + 16);
        expect_ev(K_REL,   t + 36);
        step(30);
        btn_raw = 1'b1;
        step(16);
        chk("long_release_level", int'(btn_level), 0);

        // Release commit on the long-press threshold edge: release wins.
        t = cyc;
        btn_raw = 1'b0;
        expect_ev(K_PRESS, t + 6);
        expect_ev(K_REL,   t + 16);
        step(10);
        btn_raw = 1'b1;
        step(5);
        chk("simul_level_before", int'(btn_level), 1);
        step(1);
        chk("simul_level_after", int'(btn_level), 0);
        chk("simul_long", int'(long_press_pulse), 0);
        step(12);

        // Reset mid-press, asynchronous to clk.
        t = cyc;
        btn_raw = 1'b0;
        expect_ev(K_PRESS, t + 6);
        step(9);
        #2;
        rst_async = 1'b1;
        #1;
        chk_all_zero("midreset");
        step(2);
        rst_async = 1'b0;
        c1 = cyc;
        expect_ev(K_PRESS, c1 + 6);
        expect_ev(K_REL,   c1 + 14);
        step(8);
        btn_raw = 1'b1;
        step(14);

        chk("pending_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
